// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage and its load aligner.
package mem_access_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;

    localparam int WB_DATA_W = 32;
    localparam int WB_RD_W   = 4;

    // Little-endian lane enables: one lane for byte accesses, all four otherwise.
    function automatic logic [3:0] byte_enables(input logic is_byte, input logic [1:0] off);
        return is_byte ? (BE_BYTE0 << off) : BE_WORD;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Read-data alignment: byte lane select with zero-extend, or ARMv4 rotate for words.
module mem_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [WB_DATA_W-1:0] rdata,
    input  logic [1:0]           off,
    input  logic                 is_byte,
    output logic [WB_DATA_W-1:0] data
);

    logic [7:0]           lane;
    logic [WB_DATA_W-1:0] rotated;

    // Unaligned word loads rotate the addressed byte down into bits [7:0].
    always_comb begin
        lane    = rdata[7:0];
        rotated = rdata;
        case (off)
            2'd0: begin
                lane    = rdata[7:0];
                rotated = rdata;
            end
            2'd1: begin
                lane    = rdata[15:8];
                rotated = {rdata[7:0], rdata[31:8]};
            end
            2'd2: begin
                lane    = rdata[23:16];
                rotated = {rdata[15:0], rdata[31:16]};
            end
            2'd3: begin
                lane    = rdata[31:24];
                rotated = {rdata[23:0], rdata[31:24]};
            end
            default: begin
                lane    = rdata[7:0];
                rotated = rdata;
            end
        endcase
        data = is_byte ? {24'h000000, lane} : rotated;
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: single-outstanding req/ack data-memory access and the registered MEM/WB bundle.
// Optional bus-timeout abort is built when MEM_TIMEOUT_EN is defined.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic [31:0]          ex_result,
    input  logic [31:0]          ex_store_data,
    input  logic                 ex_load,
    input  logic                 ex_store,
    input  logic                 ex_byte,
    input  logic [3:0]           ex_rd,
    input  logic                 ex_reg_write,
    output logic                 stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [3:0]           mem_be,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack,
    output logic                 wb_valid,
    output logic [WB_DATA_W-1:0] wb_data,
    output logic [WB_RD_W-1:0]   wb_rd,
    output logic                 wb_we,
    output logic                 wb_fault
);

    mem_state_e state, state_next;

    logic accept_mem;
    logic ack_done;
    logic timeout_hit;

    logic                 req_is_load;
    logic                 req_is_byte;
    logic                 req_reg_write;
    logic [1:0]           req_off;
    logic [WB_RD_W-1:0]   req_rd;
    logic [31:0]          req_result;
    logic [WB_DATA_W-1:0] load_data;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] busy_cnt;

    assign timeout_hit = (state == BUSY) && !mem_ack &&
                         (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts BUSY cycles spent waiting; restarts with every new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if (accept_mem) begin
            busy_cnt <= '0;
        end else if ((state == BUSY) && !mem_ack && !timeout_hit) begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_fault <= 1'b0;
        end else begin
            wb_fault <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign wb_fault    = 1'b0;
`endif

    mem_load_align u_load_align (
        .rdata   (mem_rdata),
        .off     (req_off),
        .is_byte (req_is_byte),
        .data    (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The ack (or abort) cycle already releases stall, so upstream advances past the finished op.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        accept_mem = 1'b0;
        ack_done   = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid && (ex_load || ex_store)) begin
                    stall      = 1'b1;
                    accept_mem = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    ack_done   = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= '0;
            wb_we         <= 1'b0;
            req_is_load   <= 1'b0;
            req_is_byte   <= 1'b0;
            req_reg_write <= 1'b0;
            req_off       <= '0;
            req_rd        <= '0;
            req_result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_mem) begin
                        mem_req       <= 1'b1;
                        mem_we        <= ex_store;
                        mem_addr      <= {ex_result[ADDR_W-1:2], 2'b00};
                        mem_be        <= byte_enables(ex_byte, ex_result[1:0]);
                        mem_wdata     <= ex_byte ? {4{ex_store_data[7:0]}} : ex_store_data;
                        req_is_load   <= ex_load;
                        req_is_byte   <= ex_byte;
                        req_reg_write <= ex_reg_write;
                        req_off       <= ex_result[1:0];
                        req_rd        <= ex_rd;
                        req_result    <= ex_result;
                        wb_valid      <= 1'b0;
                    end else if (ex_valid) begin
                        wb_valid <= 1'b1;
                        wb_data  <= ex_result;
                        wb_rd    <= ex_rd;
                        wb_we    <= ex_reg_write;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (ack_done) begin
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_data  <= req_is_load ? load_data : req_result;
                        wb_rd    <= req_rd;
                        wb_we    <= req_is_load && req_reg_write;
                    end else if (timeout_hit) begin
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_data  <= req_result;
                        wb_rd    <= req_rd;
                        wb_we    <= 1'b0;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                default: begin
                    mem_req  <= 1'b0;
                    wb_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
